// File: rtl/evt_pulse_queue.sv
// Counts rising edges of a synchronised event level into a pending queue drained by a
// valid/ready consumer, with overflow and stuck-input sticky flags.
module evt_pulse_queue #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned TOT_W    = 16,
  parameter int unsigned MAX_HIGH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             event_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pend_cnt,
  output logic [TOT_W-1:0] total_cnt,
  output logic             ovf,
  output logic             stuck,
  input  logic             err_clr
);

  localparam int unsigned RUN_W = 8;
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(MAX_HIGH);
  localparam logic [RUN_W-1:0] RUN_MAX_M1 = RUN_W'(MAX_HIGH - 1);

  logic             event_q;
  logic [RUN_W-1:0] high_run;
  logic             rise;
  logic             accept;
  logic             pend_full;
  logic             ovf_set;
  logic             stuck_set;
  logic [CNT_W-1:0] pend_next;
  logic [RUN_W-1:0] run_next;

  // evt_valid depends only on the registered count, never on evt_ready
  assign evt_valid = (pend_cnt != '0);

  always_comb begin
    rise      = event_in & ~event_q;
    accept    = evt_valid & evt_ready;
    pend_full = (pend_cnt == '1);
    ovf_set   = rise & ~accept & pend_full;
    stuck_set = event_in && (high_run == RUN_MAX_M1);

    pend_next = pend_cnt;
    if (rise && !accept && !pend_full) begin
      pend_next = pend_cnt + 1'b1;
    end else if (!rise && accept) begin
      pend_next = pend_cnt - 1'b1;
    end

    run_next = high_run;
    if (!event_in) begin
      run_next = '0;
    end else if (high_run != RUN_MAX) begin
      run_next = high_run + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_q   <= 1'b0;
      pend_cnt  <= '0;
      total_cnt <= '0;
      high_run  <= '0;
      ovf       <= 1'b0;
      stuck     <= 1'b0;
    end else begin
      event_q   <= event_in;
      pend_cnt  <= pend_next;
      high_run  <= run_next;
      if (rise) begin
        total_cnt <= total_cnt + 1'b1;
      end
      // set has priority over clear so a coincident event is never hidden
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
      if (stuck_set) begin
        stuck <= 1'b1;
      end else if (err_clr) begin
        stuck <= 1'b0;
      end
    end
  end

endmodule

// File: doc/evt_pulse_queue.md
EVT_PULSE_QUEUE -- requirements
Module: evt_pulse_queue

Interface
REQ-001 Parameter CNT_W, default 4: width of the pending-event counter.
REQ-002 Parameter TOT_W, default 16: width of the total-event counter.
REQ-003 Parameter MAX_HIGH, default 8: consecutive high cycles on event_in that flag a stuck input; legal range 2 to 255.
REQ-004 clk  input  1  destination-domain clock; all logic on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset; already synchronised to clk upstream.
REQ-006 event_in  input  1  stretched, synchronised event level from the upstream fast-to-slow crossing stage.
REQ-007 evt_valid  output  1  at least one event pending.
REQ-008 evt_ready  input  1  consumer accepts one event when high together with evt_valid.
REQ-009 pend_cnt  output  CNT_W  number of pending, unaccepted events.
REQ-010 total_cnt  output  TOT_W  count of all detected events.
REQ-011 ovf  output  1  sticky flag: an event was lost because the pending counter was full.
REQ-012 stuck  output  1  sticky flag: event_in stayed high for MAX_HIGH or more consecutive cycles.
REQ-013 err_clr  input  1  single-cycle clear for ovf and stuck.

Function
REQ-014 The block SHALL register event_in into event_q every clk edge.
REQ-015 rise SHALL be defined as event_in high and event_q low; one rise equals one event, whatever the high duration.
REQ-016 On the edge where rise is true, pend_cnt SHALL increment, and evt_valid SHALL be high from that edge onward (one-edge latency).
REQ-017 An accept SHALL occur on any edge with evt_valid and evt_ready both high; pend_cnt SHALL decrement on that edge.
REQ-018 If rise and an accept occur on the same edge, pend_cnt SHALL remain unchanged and the event SHALL NOT be lost, including when pend_cnt is at maximum.
REQ-019 If rise occurs with pend_cnt equal to 2^CNT_W-1 and no accept, pend_cnt SHALL hold and ovf SHALL be set on that edge.
REQ-020 evt_valid SHALL equal (pend_cnt != 0) and SHALL be derived from registered state only, with no combinational path from evt_ready.
REQ-021 evt_ready while evt_valid is low SHALL have no effect; pend_cnt SHALL never underflow.
REQ-022 total_cnt SHALL increment on every rise, including events lost to overflow, and SHALL wrap modulo 2^TOT_W.
REQ-023 A high-run counter, saturating at MAX_HIGH, SHALL count consecutive edges with event_in high and SHALL clear on any edge with event_in low.
REQ-024 stuck SHALL be set on the edge where the high-run counter reaches MAX_HIGH.
REQ-025 err_clr SHALL clear ovf and stuck on the next edge.
REQ-026 If a set condition coincides with err_clr, the set SHALL win and the flag SHALL be high after that edge.
REQ-027 err_clr SHALL NOT affect pend_cnt, total_cnt or the high-run counter.

Reset
REQ-028 While rst_n is low, event_q, pend_cnt, total_cnt, the high-run counter, ovf and stuck SHALL be 0, and evt_valid SHALL be 0.
REQ-029 Reset assertion SHALL take effect immediately (asynchronous); pending events SHALL be discarded.
REQ-030 If event_in is high at the first edge after reset release, it SHALL count as a rise.

Verification
REQ-031 event_in high for 3 cycles, evt_ready=0 -> pend_cnt=1, total_cnt=1, evt_valid high one edge after the first high sample.
REQ-032 4 separated pulses, evt_ready held 1 -> each event accepted one edge after it is pending; pend_cnt returns to 0; total_cnt=4; ovf=0.
REQ-033 CNT_W=4, 16 pulses with evt_ready=0 -> pend_cnt=15, ovf=1, total_cnt=16; then err_clr -> ovf=0, pend_cnt=15.
REQ-034 pend_cnt=15, rise and accept on the same edge -> pend_cnt=15, ovf stays 0.
REQ-035 event_in high for 8 cycles (MAX_HIGH=8) -> stuck=1 on the 8th edge; err_clr while high -> stuck=0; 7-cycle pulse -> stuck stays 0.
REQ-036 rst_n asserted mid-run with pend_cnt=5 -> all outputs 0 immediately; event_in high at release -> pend_cnt=1 after the first edge.
